// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_pkg
// Description : Shared AHB-Lite encodings and line-fetch definitions used by
//               the instruction-cache refill master.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

  // AHB transfer types; declaration order gives IDLE=00 .. SEQ=11
  typedef enum logic [1:0] {
    HTRANS_IDLE,
    HTRANS_BUSY,
    HTRANS_NONSEQ,
    HTRANS_SEQ
  } htrans_t;

  localparam logic [2:0] HBURST_INCR4 = 3'b011;
  localparam logic [2:0] HBURST_WRAP4 = 3'b010;

  localparam logic [2:0] HSIZE_WORD   = 3'b010;
  // Opcode fetch, privileged access
  localparam logic [3:0] HPROT_OPCODE = 4'b0010;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_ADDR,
    FS_BURST,
    FS_LAST,
    FS_DONE
  } fetch_state_t;

  localparam int LINE_WORDS = 4;

  // Line word carried by a given beat; wrapping bursts start at the
  // requested word and rotate through the line modulo four.
  function automatic logic [1:0] beat_word(input logic [1:0] start_word,
                                           input logic [1:0] beat,
                                           input logic       wrap);
    beat_word = wrap ? (start_word + beat) : beat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_assembler.sv
`default_nettype none
// ============================================================================
// Module      : line_assembler
// Description : Cache-line lane register. Each captured AHB beat is written
//               into the 32-bit lane selected by its line word index; lanes
//               not written keep their previous contents.
// Revision    : 1.0 - initial release
// ============================================================================
module line_assembler #(
  parameter int HDATA_W = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cap_en,
  input  logic [1:0]                              cap_word,
  input  logic [HDATA_W-1:0]                      cap_data,
  output logic [ahb_pkg::LINE_WORDS*HDATA_W-1:0]  line
);
  import ahb_pkg::*;

  logic [LINE_WORDS*HDATA_W-1:0] r_line;

  // Write the selected lane on each accepted beat; others hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line <= '0;
    end else begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        if (cap_en && (cap_word == i[1:0])) begin
          r_line[i*HDATA_W +: HDATA_W] <= cap_data;
        end
      end
    end
  end

  assign line = r_line;

endmodule
`default_nettype wire

// File: rtl/ahb_line_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ahb_line_fetch
// Description : Instruction-cache line refill master. Runs one 4-beat 32-bit
//               AHB-Lite read burst per request and returns the assembled
//               128-bit line with a one-cycle ready pulse (plus an error flag
//               if the slave answered ERROR).
//               Build option: CRITICAL_WORD_FIRST_EN selects a WRAP4 burst
//               that starts at the requested word; otherwise INCR4 from the
//               line-aligned address.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_line_fetch #(
  parameter int LINE_W  = 128,
  parameter int HDATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [31:0]        req_addr,
  output logic [LINE_W-1:0]  line_data,
  output logic               line_ready,
  output logic               line_err,
  output logic [31:0]        haddr,
  output logic [1:0]         htrans,
  output logic [2:0]         hburst,
  output logic [2:0]         hsize,
  output logic               hwrite,
  output logic [3:0]         hprot,
  input  logic [HDATA_W-1:0] hrdata,
  input  logic               hready,
  input  logic               hresp
);
  import ahb_pkg::*;

  localparam logic [2:0] c_st_idle  = FS_IDLE;
  localparam logic [2:0] c_st_addr  = FS_ADDR;
  localparam logic [2:0] c_st_burst = FS_BURST;
  localparam logic [2:0] c_st_last  = FS_LAST;
  localparam logic [2:0] c_st_done  = FS_DONE;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam logic [2:0] c_hburst = HBURST_WRAP4;
  localparam logic       c_wrap   = 1'b1;
`else
  localparam logic [2:0] c_hburst = HBURST_INCR4;
  localparam logic       c_wrap   = 1'b0;
`endif

  logic [2:0]  r_state;
  logic [27:0] r_line_base;
  logic [1:0]  r_start_word;
  logic [1:0]  r_addr_cnt;   // beat currently in its address phase
  logic [1:0]  r_data_cnt;   // beat currently in its data phase
  logic [1:0]  r_htrans;
  logic [31:0] r_haddr;
  logic        r_line_ready;
  logic        r_line_err;

  logic        w_data_phase;
  logic        w_err_first;
  logic        w_err_last;
  logic        w_cap;
  logic [1:0]  w_cap_word;
  logic [1:0]  w_next_cnt;
  logic [31:0] w_next_addr;
  logic        w_unused;

  // A data phase is open whenever a previously accepted beat is outstanding
  assign w_data_phase = (r_state == c_st_burst) || (r_state == c_st_last);
  // Two-cycle ERROR response: first cycle stalls, second completes
  assign w_err_first  = w_data_phase && !hready && hresp;
  assign w_err_last   = w_data_phase &&  hready && hresp;
  assign w_cap        = w_data_phase &&  hready && !hresp;
  assign w_cap_word   = beat_word(r_start_word, r_data_cnt, c_wrap);
  assign w_next_cnt   = r_addr_cnt + 2'd1;
  assign w_next_addr  = {r_line_base, beat_word(r_start_word, w_next_cnt, c_wrap), 2'b00};

  // Byte offset within a word is irrelevant to a word-sized fetch
  assign w_unused = ^req_addr[1:0];

  // Burst sequencing: address phase generation, beat counting, ready pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= c_st_idle;
      r_line_base  <= '0;
      r_start_word <= '0;
      r_addr_cnt   <= '0;
      r_data_cnt   <= '0;
      r_htrans     <= HTRANS_IDLE;
      r_haddr      <= '0;
      r_line_ready <= 1'b0;
      r_line_err   <= 1'b0;
    end else begin
      if (w_cap) begin
        r_data_cnt <= r_data_cnt + 2'd1;
      end
      case (r_state)
        c_st_idle: begin
          if (req_valid) begin
            r_line_base  <= req_addr[31:4];
            r_start_word <= req_addr[3:2];
            r_addr_cnt   <= 2'd0;
            r_data_cnt   <= 2'd0;
            r_htrans     <= HTRANS_NONSEQ;
            r_haddr      <= {req_addr[31:4], beat_word(req_addr[3:2], 2'd0, c_wrap), 2'b00};
            r_state      <= c_st_addr;
          end
        end
        c_st_addr: begin
          if (hready) begin
            r_addr_cnt <= w_next_cnt;
            r_htrans   <= HTRANS_SEQ;
            r_haddr    <= w_next_addr;
            r_state    <= c_st_burst;
          end
        end
        c_st_burst: begin
          if (w_err_last) begin
            r_htrans     <= HTRANS_IDLE;
            r_line_ready <= 1'b1;
            r_line_err   <= 1'b1;
            r_state      <= c_st_done;
          end else if (w_err_first) begin
            // Cancel the beat whose address is on the bus and all later ones
            r_htrans <= HTRANS_IDLE;
          end else if (hready) begin
            if (r_addr_cnt == 2'd3) begin
              r_htrans <= HTRANS_IDLE;
              r_state  <= c_st_last;
            end else begin
              r_addr_cnt <= w_next_cnt;
              r_haddr    <= w_next_addr;
            end
          end
        end
        c_st_last: begin
          if (w_err_last) begin
            r_line_ready <= 1'b1;
            r_line_err   <= 1'b1;
            r_state      <= c_st_done;
          end else if (w_cap) begin
            r_line_ready <= 1'b1;
            r_state      <= c_st_done;
          end
        end
        c_st_done: begin
          r_line_ready <= 1'b0;
          r_line_err   <= 1'b0;
          r_state      <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  line_assembler #(
    .HDATA_W (HDATA_W)
  ) u_line_assembler (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (w_cap),
    .cap_word (w_cap_word),
    .cap_data (hrdata),
    .line     (line_data)
  );

  // The only combinational response path: ERROR forces IDLE immediately
  assign htrans     = w_err_first ? HTRANS_IDLE : r_htrans;
  assign haddr      = r_haddr;
  assign hburst     = c_hburst;
  assign hsize      = HSIZE_WORD;
  assign hwrite     = 1'b0;
  assign hprot      = HPROT_OPCODE;
  assign line_ready = r_line_ready;
  assign line_err   = r_line_err;

endmodule
`default_nettype wire

// File: tb/tb_ahb_line_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_line_fetch
// Description : Self-checking bench for ahb_line_fetch. Each fetch is laid
//               out as an AHB pipeline timeline (address phase of beat n+1
//               overlapping the data phase of beat n) which yields both the
//               slave stimulus and the expected outputs for every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_line_fetch;

  localparam int NCYC = 128;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam logic [2:0] EXP_HBURST = 3'b010;
`else
  localparam logic [2:0] EXP_HBURST = 3'b011;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [127:0] line_data;
  logic         line_ready, line_err;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic [2:0]   hburst, hsize;
  logic         hwrite;
  logic [3:0]   hprot;
  logic [31:0]  hrdata = '0;
  logic         hready = 1'b1;
  logic         hresp = 1'b0;

  always #5 clk = ~clk;

  ahb_line_fetch #(.LINE_W(128), .HDATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .line_data(line_data), .line_ready(line_ready), .line_err(line_err),
    .haddr(haddr), .htrans(htrans), .hburst(hburst), .hsize(hsize),
    .hwrite(hwrite), .hprot(hprot), .hrdata(hrdata), .hready(hready),
    .hresp(hresp)
  );

  // Stimulus timeline
  logic         s_rst_low [NCYC];
  logic         s_req     [NCYC];
  logic [31:0]  s_addr    [NCYC];
  logic         s_hready  [NCYC];
  logic         s_hresp   [NCYC];
  logic [31:0]  s_hrdata  [NCYC];
  // Expected outputs
  logic [1:0]   e_htrans  [NCYC];
  logic         e_achk    [NCYC];
  logic [31:0]  e_haddr   [NCYC];
  logic         e_ready   [NCYC];
  logic         e_err     [NCYC];
  logic [127:0] e_line    [NCYC];
  // Lane writes completing at the end of a cycle
  logic         ev_v      [NCYC];
  int           ev_lane   [NCYC];
  logic [31:0]  ev_data   [NCYC];
  int           ev_stale  [NCYC];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic running = 1'b0;
  int lit_cyc1, lit_cyc7;

  function automatic logic [1:0] word_of(input logic [31:0] a, input int k);
    int w;
`ifdef CRITICAL_WORD_FIRST_EN
    w = (int'(a[3:2]) + k) % 4;
`else
    w = k % 4;
`endif
    return w[1:0];
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k);
    return {a[31:4], word_of(a, k), 2'b00};
  endfunction

  // Slave memory contents
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a[31:4] == 28'h0000123) return 32'hA0 + 32'(a[3:2]);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Lay out one fetch: request seen in cycle r, optional wait states on the
  // data phase of beat wbeat, optional ERROR on the data phase of beat ebeat.
  task automatic sched_fetch(input int r, input logic [31:0] a, input int wbeat,
                             input int wn, input int ebeat, output int rdy);
    int c;
    int nw;
    c = r + 1;
    e_htrans[c] = 2'b10; e_achk[c] = 1'b1; e_haddr[c] = beat_addr(a, 0);
    c++;
    rdy = -1;
    for (int b = 0; b < 4 && rdy < 0; b++) begin
      if (b == ebeat) begin
        s_hready[c] = 1'b0; s_hresp[c] = 1'b1; s_hrdata[c] = 32'hEEEE_0001;
        s_hready[c+1] = 1'b1; s_hresp[c+1] = 1'b1; ev_stale[c+1] = int'(word_of(a, b));
        rdy = c + 2;
        e_err[rdy] = 1'b1;
      end else begin
        nw = (b == wbeat) ? wn : 0;
        for (int j = 0; j <= nw; j++) begin
          if (b < 3) begin
            e_htrans[c] = 2'b11; e_achk[c] = 1'b1; e_haddr[c] = beat_addr(a, b + 1);
          end
          s_hready[c] = (j == nw);
          s_hrdata[c] = (j == nw) ? mem(beat_addr(a, b)) : 32'hBAD0_0000 + 32'(j);
          if (j == nw) begin
            ev_v[c] = 1'b1; ev_lane[c] = int'(word_of(a, b)); ev_data[c] = mem(beat_addr(a, b));
          end
          c++;
        end
      end
    end
    if (rdy < 0) rdy = c;
    e_ready[rdy] = 1'b1;
    for (int t = r; t <= rdy; t++) begin
      s_req[t] = 1'b1; s_addr[t] = a;
    end
  endtask

  // Reset held low for cycles c0..c1 kills the fetch that would end at rdy
  task automatic abort_fetch(input int c0, input int c1, input int rdy);
    for (int t = c0; t <= rdy; t++) begin
      s_req[t] = 1'b0; e_htrans[t] = 2'b00; e_achk[t] = 1'b0; e_ready[t] = 1'b0;
      e_err[t] = 1'b0; ev_v[t] = 1'b0; ev_stale[t] = -1; s_hready[t] = 1'b1; s_hresp[t] = 1'b0;
    end
    for (int t = c0; t <= c1; t++) begin
      s_rst_low[t] = 1'b1; e_achk[t] = 1'b1; e_haddr[t] = 32'h0;
    end
  endtask

  task automatic apply(input int c);
    rst = !s_rst_low[c];
    req_valid = s_req[c];
    req_addr = s_addr[c];
    hready = s_hready[c];
    hresp = s_hresp[c];
    hrdata = s_hrdata[c];
  endtask

  // Per-cycle comparison against the timeline
  initial begin
    forever begin
      @(negedge clk);
      if (running) begin
        chk("htrans", 128'(htrans), 128'(e_htrans[cyc]));
        if (e_achk[cyc]) chk("haddr", 128'(haddr), 128'(e_haddr[cyc]));
        chk("line_ready", 128'(line_ready), 128'(e_ready[cyc]));
        chk("line_err", 128'(line_err), 128'(e_err[cyc]));
        chk("line_data", line_data, e_line[cyc]);
        chk("hburst", 128'(hburst), 128'(EXP_HBURST));
        chk("hsize", 128'(hsize), 128'(3'b010));
        chk("hwrite", 128'(hwrite), 128'(1'b0));
        chk("hprot", 128'(hprot), 128'(4'b0010));
        if (cyc == lit_cyc1 || cyc == lit_cyc7) begin
          chk("lit_line", line_data, 128'h000000A3_000000A2_000000A1_000000A0);
          chk("lit_ready", 128'(line_ready), 128'(1'b1));
        end
      end
    end
  end

  initial begin
    int rdy1, rdy2, rdy3, rdy4, rdy5, rdy6, rdy7, rdy8, rdy9, nrun;
    logic [127:0] cur;
    logic [31:0] lit_a [4];
    logic [127:0] lit_err1;

    for (int c = 0; c < NCYC; c++) begin
      s_rst_low[c] = 1'b0; s_req[c] = 1'b0; s_addr[c] = 32'h0; s_hready[c] = 1'b1;
      s_hresp[c] = 1'b0; s_hrdata[c] = 32'hDEAD_0000 + 32'(c);
      e_htrans[c] = 2'b00; e_achk[c] = 1'b0; e_haddr[c] = 32'h0; e_ready[c] = 1'b0;
      e_err[c] = 1'b0; e_line[c] = '0; ev_v[c] = 1'b0; ev_lane[c] = 0; ev_data[c] = 32'h0;
      ev_stale[c] = -1;
    end
    for (int c = 0; c < 3; c++) begin
      s_rst_low[c] = 1'b1; e_achk[c] = 1'b1;
    end

    sched_fetch(5, 32'h0000_1238, -1, 0, -1, rdy1);           // zero-wait
    sched_fetch(rdy1 + 3, 32'h0000_1238, 1, 2, -1, rdy2);     // 2 waits on beat 1
    sched_fetch(rdy2 + 3, 32'h0000_5674, -1, 0, -1, rdy3);    // different line
    sched_fetch(rdy3 + 3, 32'h0000_1238, -1, 0, 1, rdy4);     // ERROR on beat 1
    sched_fetch(rdy4 + 3, 32'h0000_ABC4, 0, 1, 3, rdy5);      // waits, ERROR on beat 3
    sched_fetch(rdy5 + 3, 32'h0000_1238, -1, 0, -1, rdy6);    // killed by reset
    abort_fetch(rdy5 + 6, rdy5 + 7, rdy6);
    sched_fetch(rdy5 + 10, 32'h0000_1238, -1, 0, -1, rdy7);   // after reset
    sched_fetch(rdy7 + 3, 32'h8000_00F8, -1, 0, -1, rdy8);    // back-to-back pair
    sched_fetch(rdy8 + 1, 32'h0000_1234, -1, 0, -1, rdy9);
    nrun = rdy9 + 5;
    lit_cyc1 = rdy1;
    lit_cyc7 = rdy7;

    // Expected line over time, including stale lanes and reset clearing
    cur = '0;
    for (int c = 0; c < NCYC; c++) begin
      if (s_rst_low[c]) cur = '0;
      if (ev_stale[c] >= 0) s_hrdata[c] = cur[ev_stale[c]*32 +: 32];
      e_line[c] = cur;
      if (!s_rst_low[c] && ev_v[c]) cur[ev_lane[c]*32 +: 32] = ev_data[c];
    end

    // Hand-computed values that pin the timeline model
`ifdef CRITICAL_WORD_FIRST_EN
    lit_a[0] = 32'h1238; lit_a[1] = 32'h123C; lit_a[2] = 32'h1230; lit_a[3] = 32'h1234;
    lit_err1 = 128'h5A5A567C_000000A2_5A5A5674_5A5A5670;
`else
    lit_a[0] = 32'h1230; lit_a[1] = 32'h1234; lit_a[2] = 32'h1238; lit_a[3] = 32'h123C;
    lit_err1 = 128'h5A5A567C_5A5A5678_5A5A5674_000000A0;
`endif
    chk("pin_t1_latency", 128'(rdy1 - 5), 128'(6));
    chk("pin_t2_latency", 128'(rdy2 - (rdy1 + 3)), 128'(8));
    chk("pin_err_latency", 128'(rdy4 - (rdy3 + 3)), 128'(5));
    for (int k = 0; k < 4; k++) chk("pin_t1_addr", 128'(e_haddr[6 + k]), 128'(lit_a[k]));
    chk("pin_t1_line", e_line[rdy1], 128'h000000A3_000000A2_000000A1_000000A0);
    chk("pin_err_line", e_line[rdy4], lit_err1);
    chk("pin_b2b_nonseq", 128'(e_htrans[rdy8 + 2]), 128'(2'b10));

    running = 1'b1;
    cyc = 0;
    apply(0);
    for (int c = 1; c < nrun; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      apply(c);
    end
    @(posedge clk);
    #1;
    running = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_line_fetch.md
# ahb_line_fetch

Cache-line refill master between the instruction cache's main-memory interface and an AHB-Lite bus. It accepts a line-fill request (address plus request level), runs one 4-beat 32-bit AHB read burst, and assembles the beats into a 128-bit line. It then returns the line with a one-cycle ready pulse. It is the cache's only path to memory.

## Interface
Parameters:
- `LINE_W`, default 128: cache line width; fixed at 4 × `HDATA_W`.
- `HDATA_W`, default 32: AHB data width.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: line-fill request (the cache's `mem_req`), level.
- `req_addr` input 32: miss address (the cache's `mem_addr`). Only bits [31:2] are used.
- `line_data` output 128: assembled line. Word k is at bits [32k+31:32k].
- `line_ready` output 1: one-cycle pulse; `line_data` is valid in that cycle.
- `line_err` output 1: pulses together with `line_ready` when the burst ended in an ERROR response.
- `haddr` output 32: AHB address.
- `htrans` output 2: AHB transfer type. IDLE=00, NONSEQ=10, SEQ=11.
- `hburst` output 3: AHB burst type. INCR4=011, WRAP4=010.
- `hsize` output 3: constant 010 (word).
- `hwrite` output 1: constant 0.
- `hprot` output 4: constant 0010 (opcode fetch, privileged).
- `hrdata` input 32: AHB read data.
- `hready` input 1: AHB transfer done / wait-state control.
- `hresp` input 1: AHB response. 0=OKAY, 1=ERROR.

## Operation
- FSM states: IDLE, ADDR, BURST, LAST, DONE.
- IDLE:
  - `htrans`=IDLE.
  - `req_valid` is sampled only in this state.
  - When `req_valid`=1: latch `line_base`=`req_addr`[31:4] and `start_word`=`req_addr`[3:2]; go to ADDR.
- ADDR: drive NONSEQ with beat 0 address; go to BURST when `hready`=1.
- BURST:
  - Drive SEQ for beats 1..3. The address advances on each cycle with `hready`=1.
  - The data phase of beat n-1 overlaps the address phase of beat n.
  - After the beat-3 address is accepted, go to LAST and drive `htrans`=IDLE.
- LAST: capture beat-3 data when `hready`=1, then go to DONE.
- DONE: `line_ready`=1 for exactly one cycle, then IDLE.
- Beat address: {`line_base`, `word_k`, 2'b00}. Write `hrdata` into lane `word_k` whenever `hready`=1 in a data phase.
- `word_k` sequence: 0,1,2,3 by default; see Configuration for the alternative.
- Beat counter: 2 bits; wraps modulo 4.
- `line_data` holds its value from DONE until the first data capture of the next burst.
- The requester deasserts `req_valid` no later than the cycle after `line_ready`. A request still high in IDLE starts a new fetch (back-to-back allowed).
- ERROR response (cycle 1: `hready`=0, `hresp`=1):
  - In that same cycle, drive `htrans`=IDLE and cancel the remaining beats.
  - On cycle 2 (`hready`=1, `hresp`=1), go to DONE.
  - DONE then asserts `line_ready`=1 and `line_err`=1. `line_data` lanes not yet written keep stale values.
- Reset mid-burst:
  - All outputs go to their reset values asynchronously; the FSM goes to IDLE.
  - No `line_ready` is generated for the aborted burst.
- `hsize`, `hwrite` and `hprot` are constant. `hburst` is constant per build.

## Timing
- Reset values:
  - `htrans`=00, `haddr`=0, `line_data`=0, `line_ready`=0, `line_err`=0.
  - `hburst`, `hsize`, `hwrite`, `hprot` take their constants.
- Zero-wait sequence, with `req_valid` first high in cycle T0:
  - T1: NONSEQ beat 0.
  - T2–T4: SEQ beats 1–3; beats 0–2 data captured.
  - T5: `htrans`=IDLE; beat 3 data captured.
  - T6: `line_ready`=1.
- Latency: 6 cycles from request to ready, plus 1 cycle per `hready`=0 cycle.
- All outputs are registered. No combinational path from `hrdata`, `hready` or `hresp` to any output except the same-cycle `htrans`→IDLE on ERROR.

## Configuration
- `CRITICAL_WORD_FIRST_EN` defined:
  - `hburst`=WRAP4.
  - `word_k` = (`start_word`+k) mod 4.
  - The requested word arrives first.
- `CRITICAL_WORD_FIRST_EN` undefined:
  - `hburst`=INCR4.
  - `word_k`=k; the burst starts at the line-aligned address.
- Lane placement by `word_k` keeps `line_data` identical in both builds.

## Structure
- Shared package `ahb_pkg`:
  - `htrans_t` enum (IDLE, BUSY, NONSEQ, SEQ).
  - `hburst` constants (INCR4, WRAP4).
  - `HSIZE_WORD`, `HPROT_OPCODE`.
  - `fetch_state_t` enum.
  - `LINE_WORDS`=4.
- Sub-module `line_assembler`: 128-bit lane register written by (`word_k`, `hrdata`, capture enable). The FSM and address generation stay in the top.

## Test plan
- Zero-wait fetch, INCR4 build: `req_addr`=0x0000_1238, slave returns 0xA0,0xA1,0xA2,0xA3.
  - `haddr` = 0x1230, 0x1234, 0x1238, 0x123C.
  - `line_ready` in T6.
  - `line_data`=0x000000A3_000000A2_000000A1_000000A0.
- Wait states: same request, `hready`=0 for 2 cycles on beat 1 data → `line_ready` in T8; identical `line_data`.
- `CRITICAL_WORD_FIRST_EN` build, `req_addr`=0x1238:
  - `hburst`=010.
  - `haddr` = 0x1238, 0x123C, 0x1230, 0x1234.
  - Slave returns 0xA2,0xA3,0xA0,0xA1 → `line_data` same as the first test.
- ERROR on beat 1 data phase:
  - `htrans`=IDLE in the first ERROR cycle.
  - `line_ready`=1 and `line_err`=1 one cycle after the second ERROR cycle.
  - No further beats issued.
- `rst` low during beat 2:
  - `htrans`=00 and `line_ready`=0 immediately.
  - After release, a new request fetches correctly.
- Back-to-back: `req_valid` held through `line_ready` with a new address → second NONSEQ in the cycle after IDLE; two correct lines.
